// File: rtl/pipeline_pkg.sv
// Shared definitions for the MEM/WB skid register.
// Provides the buffer state encoding, default datapath widths and the width
// of the packed write-back bundle carried through the main and skid entries.
package pipeline_pkg;

  typedef logic [1:0] state_t;

  // Encoding doubles as the occupancy count.
  localparam state_t ST_EMPTY = 2'd0;
  localparam state_t ST_ONE   = 2'd1;
  localparam state_t ST_FULL  = 2'd2;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;

  // reg_wr, to_pc, to_hi, to_lo
  localparam int CTRL_W = 4;

  // Packed bundle: {mem_data, alu_result, alu_result_low, waddr, controls}
  function automatic int bundle_w(input int data_w, input int addr_w);
    return 3 * data_w + addr_w + CTRL_W;
  endfunction

endpackage

// File: rtl/wb_bundle_reg.sv
// Enable-loaded register holding one packed write-back bundle.
// Used for both the visible main entry and the hidden skid entry.
// Ports:
//   clk  - clock, rising edge
//   rst  - synchronous active-high reset, clears the held bundle
//   ld   - load d on the next rising edge
//   d    - incoming bundle
//   q    - held bundle
module wb_bundle_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ld,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // NOTE: the payload is reset (not just the valid state) because the
  // write-back outputs must read 0 straight out of reset; flush leaves it.
  always_ff @(posedge clk) begin
    if (rst)     q <= '0;
    else if (ld) q <= d;
  end

endmodule

// File: rtl/mem_wb_skid.sv
// MEM/WB pipeline register with valid/ready handshake, optional one-entry
// skid buffer, synchronous flush and HI/LO write-enable channels.
// Ports:
//   clk, rst              - clock (rising edge), synchronous active-high reset
//   flush                 - synchronous clear of all held entries
//   in_valid / in_ready   - MEM-side handshake
//   mem_*                 - MEM-stage result bundle
//   out_valid / out_ready - WB-side handshake
//   wb_*                  - registered bundle; reg_wr/to_hi/to_lo gated by out_valid
//   occupancy             - entries held (0..2)
module mem_wb_skid
  import pipeline_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter bit SKID_EN = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] mem_mem_data,
  input  logic [DATA_W-1:0] mem_alu_result,
  input  logic [DATA_W-1:0] mem_alu_result_low,
  input  logic              mem_reg_wr,
  input  logic [ADDR_W-1:0] mem_waddr,
  input  logic              mem_to_pc,
  input  logic              mem_to_hi,
  input  logic              mem_to_lo,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] wb_mem_data,
  output logic [DATA_W-1:0] wb_alu_result,
  output logic [DATA_W-1:0] wb_alu_result_low,
  output logic              wb_reg_wr,
  output logic              wb_to_hi,
  output logic              wb_to_lo,
  output logic              wb_to_pc,
  output logic [ADDR_W-1:0] wb_waddr,
  output logic [1:0]        occupancy
);

  localparam int BW = bundle_w(DATA_W, ADDR_W);

  state_t          st, st_nxt;
  logic [BW-1:0]   in_bundle, main_d, main_q, skid_q;
  logic            main_ld, skid_ld, main_from_skid;
  logic            accept, pop;
  logic            main_reg_wr, main_to_hi, main_to_lo;

  assign in_bundle = {mem_mem_data, mem_alu_result, mem_alu_result_low, mem_waddr,
                      mem_reg_wr, mem_to_pc, mem_to_hi, mem_to_lo};

  // Handshake signals decode registered state only; without the skid the
  // ready path is combinational from out_ready by design.
  assign out_valid = (st != ST_EMPTY);
  assign in_ready  = SKID_EN ? (st != ST_FULL) : (!out_valid || out_ready);
  assign accept    = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

  // State register
  always_ff @(posedge clk) begin
    if (rst) st <= ST_EMPTY;
    else     st <= st_nxt;
  end

  // Next-state logic; flush discards everything including this cycle's input.
  always_comb begin
    st_nxt = st;
    if (flush) begin
      st_nxt = ST_EMPTY;
    end else begin
      case (st)
        ST_EMPTY: if (accept) st_nxt = ST_ONE;
        ST_ONE: begin
          // Without the skid, accept in ONE implies pop, so FULL is unreachable.
          if (accept && !pop)      st_nxt = SKID_EN ? ST_FULL : ST_ONE;
          else if (!accept && pop) st_nxt = ST_EMPTY;
        end
        ST_FULL:  if (pop) st_nxt = ST_ONE;
        default:  st_nxt = ST_EMPTY;
      endcase
    end
  end

  // Output / datapath control
  always_comb begin
    // NOTE: every signal gets a default first so no path through the
    // case statement infers a latch.
    main_ld        = 1'b0;
    skid_ld        = 1'b0;
    main_from_skid = 1'b0;
    occupancy      = st;
    if (!flush) begin
      case (st)
        ST_EMPTY: main_ld = accept;
        ST_ONE: begin
          if (accept && pop) main_ld = 1'b1;
          else if (accept)   skid_ld = 1'b1;
        end
        ST_FULL: begin
          main_ld        = pop;
          main_from_skid = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign main_d = main_from_skid ? skid_q : in_bundle;

  wb_bundle_reg #(.W(BW)) u_main (
    .clk (clk),
    .rst (rst),
    .ld  (main_ld),
    .d   (main_d),
    .q   (main_q)
  );

  wb_bundle_reg #(.W(BW)) u_skid (
    .clk (clk),
    .rst (rst),
    .ld  (skid_ld),
    .d   (in_bundle),
    .q   (skid_q)
  );

  assign {wb_mem_data, wb_alu_result, wb_alu_result_low, wb_waddr,
          main_reg_wr, wb_to_pc, main_to_hi, main_to_lo} = main_q;

  // A bubble must never write the register file or HI/LO.
  assign wb_reg_wr = main_reg_wr && out_valid;
  assign wb_to_hi  = main_to_hi  && out_valid;
  assign wb_to_lo  = main_to_lo  && out_valid;

endmodule

// File: tb/tb_mem_wb_skid.sv
module tb_mem_wb_skid;

  localparam int DW = 32;
  localparam int AW = 5;

  typedef struct packed {
    logic [DW-1:0] mem_data;
    logic [DW-1:0] alu;
    logic [DW-1:0] low;
    logic [AW-1:0] waddr;
    logic          reg_wr;
    logic          to_pc;
    logic          to_hi;
    logic          to_lo;
  } bundle_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Index 0: SKID_EN=0, index 1: SKID_EN=1
  logic          flush     [2];
  logic          in_valid  [2];
  logic          in_ready  [2];
  logic          out_valid [2];
  logic          out_ready [2];
  bundle_t       in_b      [2];
  logic [DW-1:0] wb_mem_data [2];
  logic [DW-1:0] wb_alu      [2];
  logic [DW-1:0] wb_low      [2];
  logic [AW-1:0] wb_waddr    [2];
  logic          wb_reg_wr   [2];
  logic          wb_to_hi    [2];
  logic          wb_to_lo    [2];
  logic          wb_to_pc    [2];
  logic [1:0]    occ         [2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    mem_wb_skid #(.DATA_W(DW), .ADDR_W(AW), .SKID_EN(g == 1)) u_dut (
      .clk                (clk),
      .rst                (rst),
      .flush              (flush[g]),
      .in_valid           (in_valid[g]),
      .in_ready           (in_ready[g]),
      .mem_mem_data       (in_b[g].mem_data),
      .mem_alu_result     (in_b[g].alu),
      .mem_alu_result_low (in_b[g].low),
      .mem_reg_wr         (in_b[g].reg_wr),
      .mem_waddr          (in_b[g].waddr),
      .mem_to_pc          (in_b[g].to_pc),
      .mem_to_hi          (in_b[g].to_hi),
      .mem_to_lo          (in_b[g].to_lo),
      .out_valid          (out_valid[g]),
      .out_ready          (out_ready[g]),
      .wb_mem_data        (wb_mem_data[g]),
      .wb_alu_result      (wb_alu[g]),
      .wb_alu_result_low  (wb_low[g]),
      .wb_reg_wr          (wb_reg_wr[g]),
      .wb_to_hi           (wb_to_hi[g]),
      .wb_to_lo           (wb_to_lo[g]),
      .wb_to_pc           (wb_to_pc[g]),
      .wb_waddr           (wb_waddr[g]),
      .occupancy          (occ[g])
    );
  end

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model: an ordered list of bundles accepted but not yet consumed.
  bundle_t exp_q [2][$];

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic bundle_t mk(input logic [DW-1:0] alu, input logic [DW-1:0] low,
                                 input logic [AW-1:0] waddr, input logic reg_wr,
                                 input logic to_hi, input logic to_lo);
    bundle_t b;
    b.mem_data = alu ^ 32'hA5A5_0000;
    b.alu      = alu;
    b.low      = low;
    b.waddr    = waddr;
    b.reg_wr   = reg_wr;
    b.to_pc    = alu[0];
    b.to_hi    = to_hi;
    b.to_lo    = to_lo;
    return b;
  endfunction

  function automatic bundle_t rnd_bundle();
    bundle_t b;
    b.mem_data = $urandom;
    b.alu      = $urandom;
    b.low      = $urandom;
    b.waddr    = AW'($urandom);
    b.reg_wr   = 1'($urandom);
    b.to_pc    = 1'($urandom);
    b.to_hi    = 1'($urandom);
    b.to_lo    = 1'($urandom);
    return b;
  endfunction

  task automatic drive(input logic v, input bundle_t b, input logic ordy, input logic fl);
    for (int i = 0; i < 2; i++) begin
      in_valid[i]  = v;
      in_b[i]      = b;
      out_ready[i] = ordy;
      flush[i]     = fl;
    end
  endtask

  // Advance one clock: record accepted bundles into the model at the edge.
  task automatic tick();
    logic    acc [2];
    bundle_t cap [2];
    #1;
    for (int i = 0; i < 2; i++) begin
      acc[i] = in_valid[i] && in_ready[i] && !flush[i] && !rst;
      cap[i] = in_b[i];
    end
    @(posedge clk);
    for (int i = 0; i < 2; i++) begin
      if (rst || flush[i]) exp_q[i].delete();
      else if (acc[i])     exp_q[i].push_back(cap[i]);
    end
    @(negedge clk);
  endtask

  // Directed check on the skid instance
  task automatic chk_out(input string tag, input logic v, input logic [DW-1:0] alu,
                         input logic [1:0] o, input logic ir);
    #1;
    check({tag, "_valid"}, out_valid[1], v);
    check({tag, "_occ"}, occ[1], o);
    check({tag, "_in_ready"}, in_ready[1], ir);
    if (v) check({tag, "_alu"}, wb_alu[1], alu);
  endtask

  // Monitor: compares every output transfer against the model and checks
  // occupancy, handshake and bubble gating each cycle.
  initial begin : monitor
    bundle_t obs;
    bundle_t exp;
    int      sz;
    logic    exp_ir;
    forever begin
      @(negedge clk);
      #2;
      if (!rst) begin
        for (int i = 0; i < 2; i++) begin
          sz = exp_q[i].size();
          check($sformatf("occupancy[%0d]", i), occ[i], sz);
          check($sformatf("out_valid[%0d]", i), out_valid[i], sz != 0);
          exp_ir = (i == 1) ? (sz < 2) : (sz == 0 || out_ready[i]);
          check($sformatf("in_ready[%0d]", i), in_ready[i], exp_ir);
          if (!out_valid[i])
            check($sformatf("bubble_gate[%0d]", i),
                  {wb_reg_wr[i], wb_to_hi[i], wb_to_lo[i]}, 3'b000);
          if (out_valid[i] && out_ready[i]) begin
            obs.mem_data = wb_mem_data[i];
            obs.alu      = wb_alu[i];
            obs.low      = wb_low[i];
            obs.waddr    = wb_waddr[i];
            obs.reg_wr   = wb_reg_wr[i];
            obs.to_pc    = wb_to_pc[i];
            obs.to_hi    = wb_to_hi[i];
            obs.to_lo    = wb_to_lo[i];
            if (sz == 0) begin
              check($sformatf("spurious_out[%0d]", i), 1'b1, 1'b0);
            end else begin
              exp = exp_q[i].pop_front();
              check($sformatf("bundle[%0d]", i), obs, exp);
            end
          end
        end
      end
    end
  end

  initial begin : stimulus
    bundle_t a, b, c, m;
    a = mk(32'h0000_0011, 32'h0, 5'd5, 1'b1, 1'b0, 1'b0);
    b = mk(32'h0000_0022, 32'h0, 5'd6, 1'b1, 1'b0, 1'b0);
    c = mk(32'h0000_0033, 32'h0, 5'd7, 1'b1, 1'b0, 1'b0);
    m = mk(32'hDEAD_BEEF, 32'h1234_5678, 5'd0, 1'b0, 1'b1, 1'b1);

    rst = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0);
    @(negedge clk);
    tick();
    tick();
    rst = 1'b0;
    chk_out("reset", 1'b0, '0, 2'd0, 1'b1);
    check("reset_alu", wb_alu[1], '0);
    check("reset_waddr", wb_waddr[1], '0);
    check("reset_ctrl", {wb_reg_wr[1], wb_to_pc[1], wb_to_hi[1], wb_to_lo[1]}, 4'b0);

    // 1. Streaming with out_ready=1
    drive(1'b1, a, 1'b1, 1'b0); tick();
    drive(1'b1, b, 1'b1, 1'b0); chk_out("stream_a", 1'b1, 32'h11, 2'd1, 1'b1);
    check("stream_a_waddr", wb_waddr[1], 5'd5);
    check("stream_a_reg_wr", wb_reg_wr[1], 1'b1);
    tick();
    drive(1'b1, c, 1'b1, 1'b0); chk_out("stream_b", 1'b1, 32'h22, 2'd1, 1'b1);
    tick();
    drive(1'b0, '0, 1'b1, 1'b0); chk_out("stream_c", 1'b1, 32'h33, 2'd1, 1'b1);
    tick();
    chk_out("stream_empty", 1'b0, '0, 2'd0, 1'b1);

    // 2. Back-pressure into the skid
    drive(1'b1, a, 1'b1, 1'b0); tick();
    drive(1'b1, b, 1'b0, 1'b0); chk_out("bp_one", 1'b1, 32'h11, 2'd1, 1'b1);
    tick();
    drive(1'b0, '0, 1'b0, 1'b0); chk_out("bp_full", 1'b1, 32'h11, 2'd2, 1'b0);
    tick();
    drive(1'b0, '0, 1'b1, 1'b0); chk_out("bp_hold", 1'b1, 32'h11, 2'd2, 1'b0);
    tick();
    chk_out("bp_drain_b", 1'b1, 32'h22, 2'd1, 1'b1);
    tick();

    // 3. Flush while FULL with C on the input
    drive(1'b1, a, 1'b1, 1'b0); tick();
    drive(1'b1, b, 1'b0, 1'b0); tick();
    drive(1'b1, c, 1'b0, 1'b1); tick();
    drive(1'b0, '0, 1'b0, 1'b0); chk_out("flush", 1'b0, '0, 2'd0, 1'b1);
    check("flush_reg_wr", wb_reg_wr[1], 1'b0);
    tick();
    drive(1'b0, '0, 1'b1, 1'b0); tick(); tick();
    chk_out("flush_no_c", 1'b0, '0, 2'd0, 1'b1);

    // 4. HI/LO write from a mult bundle
    drive(1'b1, m, 1'b1, 1'b0); tick();
    drive(1'b0, '0, 1'b1, 1'b0); chk_out("hilo", 1'b1, 32'hDEAD_BEEF, 2'd1, 1'b1);
    check("hilo_low", wb_low[1], 32'h1234_5678);
    check("hilo_strobes", {wb_to_hi[1], wb_to_lo[1], wb_reg_wr[1]}, 3'b110);
    tick();
    #1;
    check("hilo_one_cycle", {wb_to_hi[1], wb_to_lo[1]}, 2'b00);

    // 5. Reset while FULL
    drive(1'b1, a, 1'b1, 1'b0); tick();
    drive(1'b1, b, 1'b0, 1'b0); tick();
    rst = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0); tick();
    rst = 1'b0;
    chk_out("rst_mid", 1'b0, '0, 2'd0, 1'b1);
    check("rst_mid_payload", {wb_mem_data[1], wb_alu[1], wb_low[1], wb_waddr[1]}, '0);
    check("rst_mid_ctrl", {wb_reg_wr[1], wb_to_pc[1], wb_to_hi[1], wb_to_lo[1]}, 4'b0);

    // 6. Random traffic on both variants
    for (int cyc = 0; cyc < 10000; cyc++) begin
      for (int i = 0; i < 2; i++) begin
        in_valid[i]  = ($urandom_range(0, 3) != 0);
        out_ready[i] = ($urandom_range(0, 2) != 0);
        flush[i]     = ($urandom_range(0, 63) == 0);
        in_b[i]      = rnd_bundle();
      end
      tick();
    end

    drive(1'b0, '0, 1'b1, 1'b0);
    for (int k = 0; k < 4; k++) tick();
    #1;
    check("drain_skid0", exp_q[0].size(), 0);
    check("drain_skid1", exp_q[1].size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_wb_skid.md
Name: mem_wb_skid

Overview:
Parametrised successor to the MEM/WB pipeline register. It carries the memory-stage result bundle into write-back and adds:
- a valid/ready handshake;
- a one-entry skid buffer, so the write-back stage can back-pressure without a combinational ready path into MEM;
- a synchronous flush;
- HI/LO write-enable channels.

It sits between the MEM stage and the register-file/HI-LO write-back logic.

Parameters:
DATA_W, 32, width of mem_data, alu_result, alu_result_low
ADDR_W, 5, register-file write-address width
SKID_EN, 1, 1 = two-entry (main+skid) buffer; 0 = single entry, in_ready = !out_valid | out_ready (combinational)

Ports:
clk  input  1  clock, rising edge
rst  input  1  synchronous active-high reset
flush  input  1  synchronous clear of all held entries
in_valid  input  1  MEM bundle valid
in_ready  output  1  register can accept bundle this cycle
mem_mem_data  input  DATA_W  load data
mem_alu_result  input  DATA_W  ALU result / HI half
mem_alu_result_low  input  DATA_W  LO half of mult/div
mem_reg_wr  input  1  GPR write enable
mem_waddr  input  ADDR_W  GPR write address
mem_to_pc  input  1  select mem data for write-back
mem_to_hi  input  1  HI write enable
mem_to_lo  input  1  LO write enable
out_valid  output  1  WB bundle valid
out_ready  input  1  WB consumes bundle this cycle
wb_mem_data, wb_alu_result, wb_alu_result_low  output  DATA_W  registered payload
wb_reg_wr, wb_to_hi, wb_to_lo, wb_to_pc  output  1  registered controls
wb_waddr  output  ADDR_W  registered address
occupancy  output  2  entries held (0..2)

Behaviour:
- Reset (rst=1 at clk edge):
  - state EMPTY; all payload/control outputs 0; out_valid=0; occupancy=0.
  - in_ready=1 from the first cycle after reset.
- Transfers:
  - Input transfer = in_valid & in_ready.
  - Output transfer = out_valid & out_ready.
- Control gating: wb_reg_wr, wb_to_hi and wb_to_lo are forced 0 whenever out_valid=0, so a bubble never writes. wb_to_pc is not gated.
- Latency: 1 cycle from input transfer to out_valid when empty or draining; no combinational in->out paths.
- State machine (SKID_EN=1); main = output register, skid = hidden register:
  - EMPTY:
    - in_valid -> load main, go to ONE.
  - ONE:
    - in_valid & out_ready -> main<=input, stay ONE.
    - in_valid & !out_ready -> skid<=input, go to FULL.
    - !in_valid & out_ready -> go to EMPTY.
    - Otherwise hold.
  - FULL:
    - out_ready -> main<=skid, go to ONE.
    - Otherwise hold.
    - Input is never accepted in FULL.
- in_ready is registered: 1 in EMPTY/ONE, 0 in FULL. It is deasserted the cycle after the skid is loaded and reasserted the cycle after the skid drains.
- Ordering: strict FIFO; no bundle is dropped or duplicated under any out_ready pattern.
- Flush:
  - Priority over normal operation, lower than rst.
  - Next state EMPTY; out_valid=0; gated controls 0; in_ready=1.
  - Any input presented in the flush cycle is discarded.
  - Data payload registers may retain stale values.
- Simultaneous flush and rst: reset result.
- Reset mid-operation: both entries lost; no write-back strobe after the reset edge.
- SKID_EN=0:
  - States EMPTY/ONE only.
  - in_ready = !out_valid | out_ready.
  - Identical gating/flush rules.
- occupancy: EMPTY=0, ONE=1, FULL=2; registered.

Decomposition:
- Shared package (pipeline_pkg): state encoding localparams (ST_EMPTY=2'd0, ST_ONE=2'd1, ST_FULL=2'd2), default DATA_W/ADDR_W, and a macro/struct width constant for the packed write-back bundle (3*DATA_W+ADDR_W+4 bits).
- One natural sub-module: wb_bundle_reg, a width-parametrised enable-loaded register used for both the main and skid entries.
- The FSM lives in the top module.

Test Plan:
1. Reset then stream with out_ready=1: bundles A (alu=0x0000_0011, waddr=5, reg_wr=1), B (0x22, 6), C (0x33, 7) on consecutive cycles -> appear on wb_* one cycle later each; in_ready stays 1; occupancy stays 1.
2. Back-pressure: with ONE holding A, drop out_ready while B arrives -> FULL, occupancy=2, in_ready=0 next cycle, wb_* still A. Raise out_ready -> A consumed, then B output; no loss or duplication.
3. Flush while FULL with C presented on input -> next cycle out_valid=0, wb_reg_wr=0, occupancy=0, in_ready=1; C never appears.
4. HI/LO: mult bundle (alu=0xDEAD_BEEF, low=0x1234_5678, to_hi=1, to_lo=1, reg_wr=0) -> wb_to_hi=wb_to_lo=1 for exactly one cycle with matching data when out_ready=1.
5. Reset mid-operation: rst asserted while FULL -> all outputs 0, in_ready=1, occupancy=0 next cycle.
6. Random in_valid/out_ready for 10k cycles, both SKID_EN=0 and SKID_EN=1 -> scoreboard matches in-order, and wb_reg_wr is never 1 while out_valid=0.
